// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the RAM arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Pointer/index width for n requesters; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned PTR_W = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_id
);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[idx[PTR_W-1:0]]) begin
                found                  = 1'b1;
                gnt[idx[PTR_W-1:0]]    = 1'b1;
                gnt_id                 = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port RAM between NUM_REQ requesters:
// accept in IDLE, drive the RAM for one ACCESS cycle, hold the response in RESP.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_wr,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata,
    output logic                          busy
);

    localparam int unsigned PTR_W = ptr_w(NUM_REQ);

    arb_state_t            state;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic [PTR_W-1:0]      gnt_id;
    logic [PTR_W-1:0]      gnt_id_q;
    logic [NUM_REQ-1:0]    gnt;
    logic                  handshake;

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req_ready = (state == IDLE) ? gnt : '0;
    assign handshake = |req_ready;

    always_comb begin
        if (32'(gnt_id) + 32'd1 >= NUM_REQ) ptr_next = '0;
        else                                ptr_next = gnt_id + PTR_W'(1);
    end

    // One-hot grant selects the payload to capture.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_id_q <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        gnt_id_q <= gnt_id;
                        wr_q     <= sel_wr;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        ptr      <= ptr_next;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // RAM read data is undefined while writing, so writes report zero.
                    rdata_q <= wr_q ? '0 : ram_rdata;
                    state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_id_q]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[gnt_id_q] = 1'b1;
    end

    assign rsp_rdata = rdata_q;
    assign ram_wr    = (state == ACCESS) && wr_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural RAM and transaction-level model.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_wr, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, ram_wdata, ram_rdata;
    logic [AW-1:0]   ram_addr;
    logic            ram_wr, busy;

    logic [DW-1:0]   ram [16] = '{default: 8'h00};
    logic [DW-1:0]   model_mem [16];
    int              exp_ptr;
    int              tests = 0;
    int              fails = 0;

    mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_wr) ram[ram_addr] <= ram_wdata;
    // Garbage on the read bus while writing stands in for the tri-stated RAM output.
    assign ram_rdata = ram_wr ? 8'hEE : ram[ram_addr];

    function automatic int pick(input logic [N-1:0] v, input int start);
        for (int i = 0; i < N; i++)
            if (v[(start + i) % N]) return (start + i) % N;
        return -1;
    endfunction

    function automatic int first_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_wr[i]             = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = '0;
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
    endtask

    // Full transaction: accept, one ACCESS cycle, `hold` stalled RESP cycles, then release.
    task automatic txn(input logic [N-1:0] vld, input int hold, output int g_obs);
        int            g;
        logic [N-1:0]  one;
        logic [N-1:0]  exp_rdy;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        logic          w;
        one = 1;
        @(negedge clk);
        req_valid = vld; rsp_ready = '0;
        #1;
        g       = pick(vld, exp_ptr);
        exp_rdy = one << g;
        g_obs   = first_set(req_ready);
        a = req_addr[g*AW +: AW];
        d = req_wdata[g*DW +: DW];
        w = req_wr[g];
        tests++;
        if (req_ready !== exp_rdy || busy !== 1'b0) begin
            fails++;
            $display("FAIL accept: req_ready=%b busy=%b, want req_ready=%b busy=0", req_ready, busy, exp_rdy);
        end
        if (w) begin model_mem[a] = d; exp_rd = '0; end
        else exp_rd = model_mem[a];
        exp_ptr = (g + 1) % N;

        @(negedge clk);
        req_valid[g] = 1'b0;
        #1;
        tests++;
        if (ram_wr !== w || ram_addr !== a || ram_wdata !== d) begin
            fails++;
            $display("FAIL access_drive: wr=%b addr=%h wdata=%h, want wr=%b addr=%h wdata=%h",
                     ram_wr, ram_addr, ram_wdata, w, a, d);
        end
        tests++;
        if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL access_state: req_ready=%b rsp_valid=%b busy=%b, want 000 000 1", req_ready, rsp_valid, busy);
        end

        for (int c = 0; c <= hold; c++) begin
            @(negedge clk);
            rsp_ready = (c == hold) ? exp_rdy : ~exp_rdy;
            #1;
            tests++;
            if (rsp_valid !== exp_rdy || rsp_rdata !== exp_rd) begin
                fails++;
                $display("FAIL resp: rsp_valid=%b rdata=%h, want rsp_valid=%b rdata=%h", rsp_valid, rsp_rdata, exp_rdy, exp_rd);
            end
            tests++;
            if (ram_wr !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL resp_state: ram_wr=%b req_ready=%b busy=%b, want 0 000 1", ram_wr, req_ready, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        tests++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_rdata !== '0 || ram_wr !== 1'b0 ||
            ram_addr !== '0 || ram_wdata !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b rv=%b rd=%h wr=%b a=%h wd=%h busy=%b, want all 0",
                     req_ready, rsp_valid, rsp_rdata, ram_wr, ram_addr, ram_wdata, busy);
        end
        req_valid = 3'b110;
        #1;
        tests++;
        if (req_ready !== 3'b010) begin
            fails++;
            $display("FAIL reset_ready_comb: req_ready=%b, want 010", req_ready);
        end
        @(negedge clk); #1;
        tests++;
        if (busy !== 1'b0 || ram_wr !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_capture: busy=%b ram_wr=%b, want 0 0", busy, ram_wr);
        end
        rst = 1'b0; req_valid = '0;
        exp_ptr = 0;
    endtask

    task automatic test_write_read();
        int g;
        set_req(0, 1'b1, 4'd3, 8'hA5);
        txn(3'b001, 0, g);
        set_req(0, 1'b0, 4'd3, 8'h00);
        txn(3'b001, 0, g);
        tests++;
        if (rsp_rdata !== 8'hA5 || g !== 0) begin
            fails++;
            $display("FAIL write_read: rdata=%h grant=%0d, want A5 0", rsp_rdata, g);
        end
    endtask

    task automatic test_contention();
        int g;
        int order [4] = '{0, 1, 0, 1};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 4'd1, 8'(8'h10 + k));
            set_req(1, 1'b1, 4'd2, 8'(8'h20 + k));
            txn(3'b011, 0, g);
            tests++;
            if (g !== order[k]) begin
                fails++;
                $display("FAIL contention_order[%0d]: grant=%0d, want %0d", k, g, order[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int g;
        set_req(1, 1'b1, 4'd7, 8'h3C);
        txn(3'b010, 0, g);
        set_req(1, 1'b0, 4'd7, 8'h00);
        txn(3'b010, 5, g);
        tests++;
        if (rsp_rdata !== 8'h3C || rsp_valid !== 3'b010) begin
            fails++;
            $display("FAIL backpressure: rdata=%h rsp_valid=%b, want 3C 010", rsp_rdata, rsp_valid);
        end
    endtask

    task automatic test_wrap();
        int g;
        do_reset();
        set_req(2, 1'b1, 4'd15, 8'hFF);
        txn(3'b100, 0, g);
        tests++;
        if (g !== 2) begin fails++; $display("FAIL wrap_first: grant=%0d, want 2", g); end
        set_req(0, 1'b0, 4'd15, 8'h00);
        set_req(2, 1'b0, 4'd15, 8'h00);
        txn(3'b101, 0, g);
        tests++;
        if (g !== 0 || rsp_rdata !== 8'hFF) begin
            fails++;
            $display("FAIL wrap_ptr: grant=%0d rdata=%h, want 0 FF", g, rsp_rdata);
        end
        txn(3'b101, 0, g);
        tests++;
        if (g !== 2 || rsp_rdata !== 8'hFF) begin
            fails++;
            $display("FAIL wrap_next: grant=%0d rdata=%h, want 2 FF", g, rsp_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int g;
        set_req(0, 1'b1, 4'd5, 8'h11);
        @(negedge clk);
        req_valid = 3'b001; rsp_ready = '0;
        @(negedge clk);
        req_valid = '0;
        #1;
        tests++;
        if (ram_wr !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_access: ram_wr=%b busy=%b, want 1 1", ram_wr, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || rsp_valid !== '0 || ram_wr !== 1'b0 || ram_addr !== '0 ||
            ram_wdata !== '0 || rsp_rdata !== '0 || req_ready !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: busy=%b rv=%b wr=%b a=%h wd=%h rd=%h rdy=%b, want all 0",
                     busy, rsp_valid, ram_wr, ram_addr, ram_wdata, rsp_rdata, req_ready);
        end
        tests++;
        if (ram[5] !== 8'h11) begin
            fails++;
            $display("FAIL reset_mid_ram: ram[5]=%h, want 11", ram[5]);
        end
        model_mem[5] = 8'h11;
        exp_ptr = 0;
        set_req(0, 1'b0, 4'd5, 8'h00);
        set_req(1, 1'b0, 4'd6, 8'h00);
        txn(3'b011, 0, g);
        tests++;
        if (g !== 0 || rsp_rdata !== 8'h11) begin
            fails++;
            $display("FAIL reset_mid_ptr: grant=%0d rdata=%h, want 0 11", g, rsp_rdata);
        end
    endtask

    task automatic test_withdraw();
        set_req(0, 1'b0, 4'd3, 8'h00);
        set_req(1, 1'b1, 4'd9, 8'h77);
        @(negedge clk);
        req_valid = 3'b001; rsp_ready = '0;
        #1;
        tests++;
        if (req_ready !== 3'b001) begin fails++; $display("FAIL withdraw_accept: req_ready=%b, want 001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        req_valid = 3'b010;
        #1;
        tests++;
        if (rsp_valid !== 3'b001 || req_ready !== '0 || rsp_rdata !== 8'hA5) begin
            fails++;
            $display("FAIL withdraw_resp: rv=%b rdy=%b rd=%h, want 001 000 A5", rsp_valid, req_ready, rsp_rdata);
        end
        @(negedge clk);
        req_valid = '0; rsp_ready = 3'b001;
        @(negedge clk);
        rsp_ready = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++;
            if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || ram_wr !== 1'b0) begin
                fails++;
                $display("FAIL withdraw_idle[%0d]: busy=%b rdy=%b rv=%b wr=%b, want all 0", c, busy, req_ready, rsp_valid, ram_wr);
            end
            @(negedge clk);
        end
        exp_ptr = 1;
    endtask

    task automatic test_random();
        int g;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)), g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
        exp_ptr = 0;
        test_reset();
        test_write_read();
        test_contention();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
